// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and types for the AXI read-path arbiter.
// Optional RAW stall is controlled by the AXI_RAW_CHECK_EN macro (see axi_rd_arbiter.sv).
package axi_rd_arbiter_pkg;

   localparam logic [3:0] ID_INST_DEF = 4'd0;
   localparam logic [3:0] ID_DATA_DEF = 4'd1;

   localparam logic [0:0] AR_IDLE = 1'b0;
   localparam logic [0:0] AR_SEND = 1'b1;

   localparam logic [7:0] ARLEN_FIX   = 8'd0;
   localparam logic [1:0] ARBURST_FIX = 2'b01;
   localparam logic [1:0] ARLOCK_FIX  = 2'b00;
   localparam logic [3:0] ARCACHE_FIX = 4'd0;
   localparam logic [2:0] ARPROT_FIX  = 3'd0;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [2:0]  size;
   } ar_req_t;

   function automatic logic [2:0] size_to_arsize(input logic [1:0] sz);
      return {1'b0, sz};
   endfunction

endpackage

// File: rtl/axi_rd_arbiter_rd_outst_cnt.sv
// Outstanding-read counter for one requester: counts grants minus completed reads.
module axi_rd_arbiter_rd_outst_cnt #(
   parameter int MAX_OUTST = 2
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic empty
);

   localparam int W = $clog2(MAX_OUTST + 1);
   localparam logic [W-1:0] CNT_MAX = W'(MAX_OUTST);

   logic [W-1:0] cnt;

   // Simultaneous inc and dec cancel; the count saturates at both ends.
   always_ff @(posedge aclk) begin
      if (!aresetn)
         cnt <= '0;
      else if (inc && !dec && !full)
         cnt <= cnt + W'(1);
      else if (dec && !inc && !empty)
         cnt <= cnt - W'(1);
   end

   assign full  = (cnt >= CNT_MAX);
   assign empty = (cnt == '0);

   dec_at_empty_a: assert property (@(posedge aclk) disable iff (!aresetn) !(dec && empty));

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R path between the instruction and data read masters.
// Data has fixed priority over inst; R beats are routed back by RID.
// Define AXI_RAW_CHECK_EN to add wr_busy/wr_addr and stall data reads that hit
// the word of an in-flight write.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int         MAX_OUTST = 2,
   parameter logic [3:0] ID_INST   = ID_INST_DEF,
   parameter logic [3:0] ID_DATA   = ID_DATA_DEF
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        inst_rd_req,
   input  logic [1:0]  inst_rd_size,
   input  logic [31:0] inst_rd_addr,
   output logic        inst_rd_addr_ok,
   output logic        inst_rd_data_ok,
   output logic [31:0] inst_rd_rdata,
   input  logic        data_rd_req,
   input  logic [1:0]  data_rd_size,
   input  logic [31:0] data_rd_addr,
   output logic        data_rd_addr_ok,
   output logic        data_rd_data_ok,
   output logic [31:0] data_rd_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
`ifdef AXI_RAW_CHECK_EN
   input  logic        wr_busy,
   input  logic [31:0] wr_addr,
`endif
   output logic        rready
);

   logic [0:0] state;
   ar_req_t    ar_hold;
   ar_req_t    grant_req;
   logic       raw_stall;
   logic       inst_full, data_full, inst_empty, data_empty;
   logic       inst_elig, data_elig, ar_idle;
   logic       grant_inst, grant_data;
   logic       inst_r_hit, data_r_hit;
   logic       unused_ok;

`ifdef AXI_RAW_CHECK_EN
   assign raw_stall = wr_busy && (wr_addr[31:2] == data_rd_addr[31:2]);
   assign unused_ok = &{1'b0, rresp, inst_empty, data_empty, wr_addr[1:0]};
`else
   assign raw_stall = 1'b0;
   assign unused_ok = &{1'b0, rresp, inst_empty, data_empty};
`endif

   assign inst_elig  = inst_rd_req && !inst_full;
   assign data_elig  = data_rd_req && !data_full && !raw_stall;
   assign ar_idle    = aresetn && (state == AR_IDLE);
   assign grant_data = ar_idle && data_elig;
   assign grant_inst = ar_idle && inst_elig && !data_elig;

   assign inst_rd_addr_ok = grant_inst;
   assign data_rd_addr_ok = grant_data;

   // Request fields of whichever master wins this cycle.
   always_comb begin
      grant_req = '{id: ID_INST, addr: inst_rd_addr, size: size_to_arsize(inst_rd_size)};
      if (data_elig)
         grant_req = '{id: ID_DATA, addr: data_rd_addr, size: size_to_arsize(data_rd_size)};
   end

   // AR channel: latch the granted request, hold it until the slave takes it.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state   <= AR_IDLE;
         arvalid <= 1'b0;
         ar_hold <= '0;
      end else begin
         case (state)
            AR_IDLE: begin
               if (grant_inst || grant_data) begin
                  ar_hold <= grant_req;
                  arvalid <= 1'b1;
                  state   <= AR_SEND;
               end
            end
            default: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  state   <= AR_IDLE;
               end
            end
         endcase
      end
   end

   assign arid    = ar_hold.id;
   assign araddr  = ar_hold.addr;
   assign arsize  = ar_hold.size;
   assign arlen   = ARLEN_FIX;
   assign arburst = ARBURST_FIX;
   assign arlock  = ARLOCK_FIX;
   assign arcache = ARCACHE_FIX;
   assign arprot  = ARPROT_FIX;

   assign rready          = aresetn;
   assign inst_r_hit      = rvalid && (rid == ID_INST);
   assign data_r_hit      = rvalid && (rid == ID_DATA);
   assign inst_rd_data_ok = aresetn && inst_r_hit;
   assign data_rd_data_ok = aresetn && data_r_hit;
   assign inst_rd_rdata   = rdata;
   assign data_rd_rdata   = rdata;

   axi_rd_arbiter_rd_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_inst_cnt (
      .aclk    (aclk),
      .aresetn (aresetn),
      .inc     (grant_inst),
      .dec     (inst_r_hit && rready && rlast),
      .full    (inst_full),
      .empty   (inst_empty)
   );

   axi_rd_arbiter_rd_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_data_cnt (
      .aclk    (aclk),
      .aresetn (aresetn),
      .inc     (grant_data),
      .dec     (data_r_hit && rready && rlast),
      .full    (data_full),
      .empty   (data_empty)
   );

   rid_known_a: assert property (@(posedge aclk) disable iff (!aresetn)
      rvalid |-> (rid == ID_INST || rid == ID_DATA));

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter with a transaction-level model and scoreboard.
// Builds with or without AXI_RAW_CHECK_EN.
module tb_axi_rd_arbiter;

   localparam int MAX_OUTST = 2;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        inst_rd_req, data_rd_req;
   logic [1:0]  inst_rd_size, data_rd_size;
   logic [31:0] inst_rd_addr, data_rd_addr;
   logic        inst_rd_addr_ok, inst_rd_data_ok, data_rd_addr_ok, data_rd_data_ok;
   logic [31:0] inst_rd_rdata, data_rd_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize, arprot;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic        arvalid, arready, rready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid;
`ifdef AXI_RAW_CHECK_EN
   logic        wr_busy;
   logic [31:0] wr_addr;
`endif

   always #5 aclk = ~aclk;

   // master-side stimulus, index 0 = inst, 1 = data
   logic        req_v[2];
   logic [31:0] addr_v[2];
   logic [1:0]  size_v[2];
   assign inst_rd_req  = req_v[0];
   assign inst_rd_addr = addr_v[0];
   assign inst_rd_size = size_v[0];
   assign data_rd_req  = req_v[1];
   assign data_rd_addr = addr_v[1];
   assign data_rd_size = size_v[1];

   axi_rd_arbiter #(.MAX_OUTST(MAX_OUTST), .ID_INST(4'd0), .ID_DATA(4'd1)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .inst_rd_req(inst_rd_req), .inst_rd_size(inst_rd_size), .inst_rd_addr(inst_rd_addr),
      .inst_rd_addr_ok(inst_rd_addr_ok), .inst_rd_data_ok(inst_rd_data_ok), .inst_rd_rdata(inst_rd_rdata),
      .data_rd_req(data_rd_req), .data_rd_size(data_rd_size), .data_rd_addr(data_rd_addr),
      .data_rd_addr_ok(data_rd_addr_ok), .data_rd_data_ok(data_rd_data_ok), .data_rd_rdata(data_rd_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
`ifdef AXI_RAW_CHECK_EN
      .wr_busy(wr_busy), .wr_addr(wr_addr),
`endif
      .rready(rready)
   );

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [2:0]  size;
   } ar_exp_t;

   int total = 0;
   int bad = 0;

   // reference model: AR channel occupancy, reads in flight per master, slave queues
   bit          busy = 0;
   int          outst[2] = '{0, 0};
   ar_exp_t     ar_q[$];
   logic [31:0] pend0[$], pend1[$];
   logic [31:0] exp_r0[$], exp_r1[$];
   bit          ok_seen[2] = '{0, 0};
   int          rst_cnt = 0;

   int req_pct = 50, ar_pct = 50, r_pct = 30;
   bit stim_on = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // monitor: compare DUT outputs against the model, then advance the model
   always @(negedge aclk) begin : mon
      logic    ei, ed, gi, gd, raw;
      ar_exp_t e;
      logic [31:0] v;
      if (!aresetn) begin
         rst_cnt++;
         check("rst_inst_addr_ok", inst_rd_addr_ok, 0);
         check("rst_data_addr_ok", data_rd_addr_ok, 0);
         check("rst_inst_data_ok", inst_rd_data_ok, 0);
         check("rst_data_data_ok", data_rd_data_ok, 0);
         check("rst_rready", rready, 0);
         if (rst_cnt >= 2) begin
            check("rst_arvalid", arvalid, 0);
            check("rst_araddr", araddr, 0);
            check("rst_arid", arid, 0);
            check("rst_arsize", arsize, 0);
         end
         busy = 0;
         outst[0] = 0;
         outst[1] = 0;
         ar_q.delete();
         pend0.delete();
         pend1.delete();
         exp_r0.delete();
         exp_r1.delete();
         ok_seen[0] = 0;
         ok_seen[1] = 0;
      end else begin
         rst_cnt = 0;
         raw = 1'b0;
`ifdef AXI_RAW_CHECK_EN
         raw = wr_busy && (wr_addr[31:2] == addr_v[1][31:2]);
`endif
         ed = req_v[1] && (outst[1] < MAX_OUTST) && !raw;
         ei = req_v[0] && (outst[0] < MAX_OUTST);
         gd = !busy && ed;
         gi = !busy && ei && !ed;
         check("inst_addr_ok", inst_rd_addr_ok, gi);
         check("data_addr_ok", data_rd_addr_ok, gd);
         check("arvalid", arvalid, busy);
         check("rready", rready, 1);
         if (inst_rd_addr_ok) ok_seen[0] = 1;
         if (data_rd_addr_ok) ok_seen[1] = 1;

         if (busy && arready) begin
            if (ar_q.size() == 0) note_fail("ar_unexpected");
            else begin
               e = ar_q.pop_front();
               check("arid", arid, e.id);
               check("araddr", araddr, e.addr);
               check("arsize", arsize, e.size);
               check("arlen", arlen, 0);
               check("arburst", arburst, 2'b01);
               check("arlock_cache_prot", {arlock, arcache, arprot}, 0);
               if (e.id == 4'd0) pend0.push_back($urandom);
               else pend1.push_back($urandom);
            end
            busy = 0;
         end else if (gi || gd) begin
            e.id   = gd ? 4'd1 : 4'd0;
            e.addr = gd ? addr_v[1] : addr_v[0];
            e.size = {1'b0, (gd ? size_v[1] : size_v[0])};
            ar_q.push_back(e);
            busy = 1;
            if (gd) outst[1]++;
            else outst[0]++;
         end

         check("inst_data_ok", inst_rd_data_ok, rvalid && rid == 4'd0);
         check("data_data_ok", data_rd_data_ok, rvalid && rid == 4'd1);
         if (inst_rd_data_ok) begin
            if (exp_r0.size() == 0) note_fail("inst_r_unexpected");
            else begin
               v = exp_r0.pop_front();
               check("inst_rdata", inst_rd_rdata, v);
            end
         end
         if (data_rd_data_ok) begin
            if (exp_r1.size() == 0) note_fail("data_r_unexpected");
            else begin
               v = exp_r1.pop_front();
               check("data_rdata", data_rd_rdata, v);
            end
         end
         if (rvalid && rlast) begin
            if (rid == 4'd0) outst[0]--;
            else if (rid == 4'd1) outst[1]--;
         end
      end
   end

   // one cycle of stimulus: masters, AR ready, slave R beats, write-path status
   task automatic step();
      for (int m = 0; m < 2; m++) begin
         if (ok_seen[m]) begin
            req_v[m]   = 1'b0;
            ok_seen[m] = 0;
         end
         if (!req_v[m] && stim_on && $urandom_range(0, 99) < req_pct) begin
            req_v[m]  = 1'b1;
            addr_v[m] = 32'h1c00_0000 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(0, 3));
            size_v[m] = 2'($urandom_range(0, 2));
         end
      end
      arready = ($urandom_range(0, 99) < ar_pct);
      rvalid  = 1'b0;
      rid     = 4'($urandom_range(0, 1));
      rdata   = $urandom;
      rresp   = 2'($urandom_range(0, 3));
      rlast   = 1'b1;
      if ($urandom_range(0, 99) < r_pct && (pend0.size() + pend1.size()) > 0) begin
         if (pend1.size() == 0 || (pend0.size() > 0 && $urandom_range(0, 1) == 0)) begin
            rid   = 4'd0;
            rdata = pend0.pop_front();
            exp_r0.push_back(rdata);
         end else begin
            rid   = 4'd1;
            rdata = pend1.pop_front();
            exp_r1.push_back(rdata);
         end
         rvalid = 1'b1;
      end
`ifdef AXI_RAW_CHECK_EN
      wr_busy = ($urandom_range(0, 99) < 30);
      wr_addr = 32'h1c00_0000 + 32'($urandom_range(0, 63)) * 4;
`endif
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
         step();
      end
   endtask

   initial begin : drv
      bit hit;
      for (int m = 0; m < 2; m++) begin
         req_v[m]  = 1'b0;
         addr_v[m] = '0;
         size_v[m] = '0;
      end
      arready = 1'b0;
      rvalid  = 1'b0;
      rid     = '0;
      rdata   = '0;
      rresp   = '0;
      rlast   = 1'b0;
`ifdef AXI_RAW_CHECK_EN
      wr_busy = 1'b0;
      wr_addr = '0;
`endif
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;

      run(1500);
      r_pct = 0;                    // withhold R: counters fill to the limit
      run(60);
      r_pct = 80;
      run(300);
      req_pct = 90; ar_pct = 100; r_pct = 60;
      run(600);

      // reset while an AR is pending and reads are in flight
      r_pct = 0;
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
         run(1);
         hit = busy && (outst[0] + outst[1] >= 3);
      end
      if (!hit) note_fail("mid_reset_setup_timeout");
      aresetn  = 1'b0;
      req_v[0] = 1'b0;
      req_v[1] = 1'b0;
      rvalid   = 1'b0;
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      run(20);
      req_pct = 50; ar_pct = 60; r_pct = 40;
      run(800);

      // drain everything outstanding
      stim_on = 0; ar_pct = 100; r_pct = 100;
      run(80);
      check("ar_all_issued", ar_q.size(), 0);
      check("inst_r_all_delivered", exp_r0.size(), 0);
      check("data_r_all_delivered", exp_r1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
